// File: rtl/mask_tile_pkg.sv
// Shared types and helpers for the repeated-tile mask streamer.
package mask_tile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int PAT_MAX = 8;

  typedef logic [0:PAT_MAX-1][0:PAT_MAX-1] tile_t;

  // Row k of the tile is the pw-bit slice starting at k*pw; columns past pw are zero.
  function automatic tile_t unpack_tile(input logic [0:63] fp, input logic [3:0] pw);
    tile_t      t;
    logic [6:0] idx;
    t = '0;
    for (int k = 0; k < PAT_MAX; k++) begin
      for (int c = 0; c < PAT_MAX; c++) begin
        idx = 7'(k) * {3'b000, pw} + 7'(c);
        if ((4'(c) < pw) && (idx < 7'd64)) begin
          t[k][c] = fp[idx[5:0]];
        end else begin
          t[k][c] = 1'b0;
        end
      end
    end
    return t;
  endfunction

  function automatic logic [2:0] wrap_mod(input logic [2:0] x, input logic [3:0] m);
    logic [3:0] r;
    r = {1'b0, x};
    for (int i = 0; i < PAT_MAX; i++) begin
      if ((m != 4'd0) && (r >= m)) begin
        r = r - m;
      end else begin
        r = r;
      end
    end
    return r[2:0];
  endfunction

endpackage

// File: rtl/mask_seg_expand.sv
// Expands one tile row into a SEG_W-bit segment starting at a given column phase,
// zeroing bits past the remaining active width.
module mask_seg_expand
  import mask_tile_pkg::*;
#(
  parameter int SEG_W = 64
) (
  input  logic [0:PAT_MAX-1] tile_row,
  input  logic [3:0]         pat_w,
  input  logic [2:0]         phase,
  input  logic [11:0]        rem,
  output logic [0:SEG_W-1]   seg_bits,
  output logic [2:0]         next_phase
);

  logic [2:0] ph_s;

  // Walk the column phase across the segment with a wrap compare instead of a modulo.
  always_comb begin
    ph_s     = phase;
    seg_bits = '0;
    for (int i = 0; i < SEG_W; i++) begin
      if (12'(i) < rem) begin
        seg_bits[i] = tile_row[ph_s];
      end else begin
        seg_bits[i] = 1'b0;
      end
      if ({1'b0, ph_s} == (pat_w - 4'd1)) begin
        ph_s = 3'd0;
      end else begin
        ph_s = ph_s + 3'd1;
      end
    end
    next_phase = ph_s;
  end

endmodule

// File: rtl/mask_tile_stream.sv
// Repeated-tile exposure mask streamer with valid/ready segments and row/frame flags.
// Define MASK_TILE_SLIDE_EN to enable per-frame horizontal tile sliding.
module mask_tile_stream
  import mask_tile_pkg::*;
#(
  parameter int MAX_W = 1920,
  parameter int MAX_H = 1080,
  parameter int SEG_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [10:0]      image_sensor_w,
  input  logic [10:0]      image_sensor_h,
  input  logic [3:0]       pattern_w,
  input  logic [3:0]       pattern_h,
  input  logic [0:63]      full_pattern,
  input  logic [2:0]       slide_step,
  input  logic             right_sliding,
  input  logic             start_pattern,
  input  logic             stop_pattern,
  output logic [0:SEG_W-1] seg_data,
  output logic             seg_valid,
  input  logic             seg_ready,
  output logic             seg_last_row,
  output logic             seg_last_frame,
  output logic             busy,
  output logic             cfg_err
);

  state_t      state_r, state_next_s;
  logic [10:0] w_r, h_r, row_r;
  logic [3:0]  pw_r, ph_r;
  tile_t       tile_r;
  logic [2:0]  rph_r, cph_r;
  logic [11:0] col_r;
  logic        stop_pend_r;

  logic             cfg_ok_s, accept_s, finish_s, advance_s;
  logic             row_end_s, frame_end_s;
  logic [11:0]      rem_s;
  logic [2:0]       rph_next_s, next_phase_s, offset_s, offset_adv_s, next_off_s, row_phase_s;
  logic [0:SEG_W-1] exp_bits_s;

  assign cfg_ok_s = (pattern_w != 4'd0) && (pattern_w <= 4'd8) &&
                    (pattern_h != 4'd0) && (pattern_h <= 4'd8) &&
                    (image_sensor_w != 11'd0) && (image_sensor_w <= 11'(MAX_W)) &&
                    (image_sensor_h != 11'd0) && (image_sensor_h <= 11'(MAX_H));

  assign accept_s    = seg_valid && seg_ready;
  assign finish_s    = (state_r == ST_RUN) && accept_s && seg_last_frame && stop_pend_r;
  assign advance_s   = (state_r == ST_LOAD) || ((state_r == ST_RUN) && accept_s && !finish_s);
  assign rem_s       = {1'b0, w_r} - col_r;
  assign row_end_s   = (col_r + 12'(SEG_W)) >= {1'b0, w_r};
  assign frame_end_s = (row_r == (h_r - 11'd1));
  assign rph_next_s  = ({1'b0, rph_r} == (ph_r - 4'd1)) ? 3'd0 : (rph_r + 3'd1);

`ifdef MASK_TILE_SLIDE_EN
  logic [2:0] step_r, offset_r;
  logic       right_r;
  logic [3:0] sum_s;

  assign offset_s = offset_r;

  // Next frame's offset, kept in 0..pw-1 by a single conditional wrap.
  always_comb begin
    sum_s = {1'b0, offset_r} + {1'b0, step_r};
    if (right_r) begin
      if (sum_s >= pw_r) begin
        offset_adv_s = 3'(sum_s - pw_r);
      end else begin
        offset_adv_s = sum_s[2:0];
      end
    end else begin
      if (offset_r >= step_r) begin
        offset_adv_s = offset_r - step_r;
      end else begin
        offset_adv_s = 3'({1'b0, offset_r} + pw_r - {1'b0, step_r});
      end
    end
  end

  // Slide shadow registers; step is pre-reduced mod pw when the config is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_r   <= 3'd0;
      right_r  <= 1'b0;
      offset_r <= 3'd0;
    end else if (clk_en) begin
      if ((state_r == ST_IDLE) && start_pattern) begin
        step_r   <= wrap_mod(slide_step, pattern_w);
        right_r  <= right_sliding;
        offset_r <= 3'd0;
      end else if (advance_s && row_end_s && frame_end_s) begin
        offset_r <= offset_adv_s;
      end
    end
  end
`else
  logic unused_slide_s;
  assign unused_slide_s = ^{slide_step, right_sliding};
  assign offset_s       = 3'd0;
  assign offset_adv_s   = 3'd0;
`endif

  // Column phase at column 0 of the next row is (-offset) mod pw.
  always_comb begin
    if (frame_end_s) begin
      next_off_s = offset_adv_s;
    end else begin
      next_off_s = offset_s;
    end
    if (next_off_s == 3'd0) begin
      row_phase_s = 3'd0;
    end else begin
      row_phase_s = 3'(pw_r - {1'b0, next_off_s});
    end
  end

  mask_seg_expand #(.SEG_W(SEG_W)) u_expand (
    .tile_row   (tile_r[rph_r]),
    .pat_w      (pw_r),
    .phase      (cph_r),
    .rem        (rem_s),
    .seg_bits   (exp_bits_s),
    .next_phase (next_phase_s)
  );

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_pattern && cfg_ok_s) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: state_next_s = ST_RUN;
      ST_RUN: begin
        if (finish_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else if (clk_en) begin
      state_r <= state_next_s;
    end
  end

  // Counters run one segment ahead of the output register, which reloads on each accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_r            <= 11'd0;
      h_r            <= 11'd0;
      pw_r           <= 4'd0;
      ph_r           <= 4'd0;
      tile_r         <= '0;
      row_r          <= 11'd0;
      rph_r          <= 3'd0;
      col_r          <= 12'd0;
      cph_r          <= 3'd0;
      stop_pend_r    <= 1'b0;
      seg_data       <= '0;
      seg_valid      <= 1'b0;
      seg_last_row   <= 1'b0;
      seg_last_frame <= 1'b0;
      busy           <= 1'b0;
      cfg_err        <= 1'b0;
    end else if (clk_en) begin
      busy <= (state_next_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (start_pattern) begin
            w_r         <= image_sensor_w;
            h_r         <= image_sensor_h;
            pw_r        <= pattern_w;
            ph_r        <= pattern_h;
            tile_r      <= unpack_tile(full_pattern, pattern_w);
            cfg_err     <= !cfg_ok_s;
            row_r       <= 11'd0;
            rph_r       <= 3'd0;
            col_r       <= 12'd0;
            cph_r       <= 3'd0;
            stop_pend_r <= 1'b0;
          end
        end
        ST_LOAD, ST_RUN: begin
          if (advance_s) begin
            seg_data       <= exp_bits_s;
            seg_valid      <= 1'b1;
            seg_last_row   <= row_end_s;
            seg_last_frame <= row_end_s && frame_end_s;
            if (row_end_s) begin
              col_r <= 12'd0;
              cph_r <= row_phase_s;
              if (frame_end_s) begin
                row_r <= 11'd0;
                rph_r <= 3'd0;
              end else begin
                row_r <= row_r + 11'd1;
                rph_r <= rph_next_s;
              end
            end else begin
              col_r <= col_r + 12'(SEG_W);
              cph_r <= next_phase_s;
            end
          end else if (finish_s) begin
            seg_data       <= '0;
            seg_valid      <= 1'b0;
            seg_last_row   <= 1'b0;
            seg_last_frame <= 1'b0;
          end
          if ((state_r == ST_RUN) && stop_pattern) begin
            stop_pend_r <= 1'b1;
          end else if (finish_s) begin
            stop_pend_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_tile_stream.sv
// Self-checking bench for mask_tile_stream: directed scenarios plus randomized streams
// checked against a per-segment behavioural model.
module tb_mask_tile_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [10:0] image_sensor_w = 11'd0;
  logic [10:0] image_sensor_h = 11'd0;
  logic [3:0]  pattern_w = 4'd0;
  logic [3:0]  pattern_h = 4'd0;
  logic [0:63] full_pattern = 64'd0;
  logic [2:0]  slide_step = 3'd0;
  logic        right_sliding = 1'b0;
  logic        start_pattern = 1'b0;
  logic        stop_pattern = 1'b0;
  logic [0:63] seg_data;
  logic        seg_valid;
  logic        seg_ready = 1'b0;
  logic        seg_last_row;
  logic        seg_last_frame;
  logic        busy;
  logic        cfg_err;

  mask_tile_stream dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .image_sensor_w(image_sensor_w), .image_sensor_h(image_sensor_h),
    .pattern_w(pattern_w), .pattern_h(pattern_h), .full_pattern(full_pattern),
    .slide_step(slide_step), .right_sliding(right_sliding),
    .start_pattern(start_pattern), .stop_pattern(stop_pattern),
    .seg_data(seg_data), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_last_row(seg_last_row), .seg_last_frame(seg_last_frame),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // model configuration and stream position
  int          m_w, m_h, m_pw, m_ph, m_step;
  bit          m_right;
  logic [0:63] m_fp;
  int          m_frame, m_row, m_seg;
  bit          m_active = 1'b0;

  logic [0:63] cap_d[$];
  bit          cap_lr[$];
  bit          cap_lf[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [0:63] exp_seg(input int frame, input int row, input int seg);
    logic [0:63] b;
    int off, k, col, c;
`ifdef MASK_TILE_SLIDE_EN
    if (m_right) off = (frame * m_step) % m_pw;
    else off = (m_pw - (frame * m_step) % m_pw) % m_pw;
`else
    off = 0;
`endif
    k = row % m_ph;
    for (int i = 0; i < 64; i++) begin
      col = seg * 64 + i;
      if (col >= m_w) b[i] = 1'b0;
      else begin
        c = ((col - off) % m_pw + m_pw) % m_pw;
        b[i] = m_fp[k * m_pw + c];
      end
    end
    return b;
  endfunction

  // Compare process: transfers against the model, stability under stall/clock-gate.
  logic [0:63] h_data;
  logic        h_valid, h_lr, h_lf, h_busy;
  bit          hold_v = 1'b0;
  always @(negedge clk) begin
    int nseg;
    logic [0:63] e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_data", seg_data, h_data);
        chk("hold_valid", seg_valid, h_valid);
        chk("hold_flags", {seg_last_row, seg_last_frame}, {h_lr, h_lf});
        if (!clk_en) chk("hold_busy", busy, h_busy);
      end
      if (clk_en && seg_valid && seg_ready) begin
        if (!m_active) begin
          chk("unexpected_xfer", 1'b1, 1'b0);
        end else begin
          nseg = (m_w + 63) / 64;
          e = exp_seg(m_frame, m_row, m_seg);
          chk("seg_data", seg_data, e);
          chk("seg_last_row", seg_last_row, (m_seg == nseg - 1));
          chk("seg_last_frame", seg_last_frame, (m_seg == nseg - 1) && (m_row == m_h - 1));
          cap_d.push_back(seg_data);
          cap_lr.push_back(seg_last_row);
          cap_lf.push_back(seg_last_frame);
          m_seg++;
          if (m_seg == nseg) begin
            m_seg = 0;
            m_row++;
            if (m_row == m_h) begin
              m_row = 0;
              m_frame++;
            end
          end
        end
      end
      hold_v  = !clk_en || (seg_valid && !seg_ready);
      h_data  = seg_data;
      h_valid = seg_valid;
      h_lr    = seg_last_row;
      h_lf    = seg_last_frame;
      h_busy  = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int w, input int h, input int pw, input int ph,
                       input logic [63:0] fp, input int step, input bit right, input bit ok);
    image_sensor_w = 11'(w);
    image_sensor_h = 11'(h);
    pattern_w      = 4'(pw);
    pattern_h      = 4'(ph);
    full_pattern   = fp;
    slide_step     = 3'(step);
    right_sliding  = right;
    clk_en         = 1'b1;
    cap_d.delete();
    cap_lr.delete();
    cap_lf.delete();
    if (ok) begin
      m_w = w; m_h = h; m_pw = pw; m_ph = ph; m_fp = fp; m_step = step; m_right = right;
      m_frame = 0; m_row = 0; m_seg = 0; m_active = 1'b1;
    end
    start_pattern = 1'b1;
    tick();
    start_pattern = 1'b0;
  endtask

  task automatic stop();
    stop_pattern = 1'b1;
    clk_en = 1'b1;
    tick();
    stop_pattern = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, busy, 1'b0);
    chk({name, "_valid_low"}, seg_valid, 1'b0);
    chk({name, "_frame_boundary"}, (m_row == 0) && (m_seg == 0), 1'b1);
    m_active = 1'b0;
  endtask

  task automatic check_basic(input string tag);
    logic [5:0] lrv, lfv;
    chk({tag, "_count"}, cap_d.size(), 6);
    if (cap_d.size() == 6) begin
      chk({tag, "_seg0"}, cap_d[0], 64'h8888_8888_8888_8888);
      chk({tag, "_seg1"}, cap_d[1], 64'h8888_8888_8888_8888);
      chk({tag, "_seg2"}, cap_d[2], 64'h8000_0000_0000_0000);
      chk({tag, "_seg3"}, cap_d[3], 64'h0);
      chk({tag, "_seg5"}, cap_d[5], 64'h0);
      for (int i = 0; i < 6; i++) begin
        lrv[5-i] = cap_lr[i];
        lfv[5-i] = cap_lf[i];
      end
      chk({tag, "_lr_flags"}, lrv, 6'b001001);
      chk({tag, "_lf_flags"}, lfv, 6'b000001);
    end
  endtask

  localparam logic [63:0] P1000 = 64'h8000_0000_0000_0000;

  initial begin
    logic [0:63] d;
    logic [7:0]  sl_exp[5];
    logic [7:0]  left_exp;
    int          n;

    // reset state
    tick();
    chk("rst_seg_data", seg_data, 64'h0);
    chk("rst_ctrl", {seg_valid, seg_last_row, seg_last_frame, busy, cfg_err}, 5'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_ctrl", {seg_valid, busy, cfg_err}, 3'b0);

    // basic stream with start latency
    seg_ready = 1'b1;
    start(130, 2, 4, 2, P1000, 0, 1'b1, 1'b1);
    chk("start_busy", busy, 1'b1);
    chk("start_valid_lat", seg_valid, 1'b0);
    tick();
    chk("load_valid", seg_valid, 1'b1);
    stop();
    wait_idle(100, "basic");
    check_basic("basic");

    // backpressure mid-row
    start(130, 2, 4, 2, P1000, 0, 1'b1, 1'b1);
    tick(); tick();
    seg_ready = 1'b0;
    d = seg_data;
    repeat (5) tick();
    chk("bp_data_stable", seg_data, d);
    chk("bp_valid_stable", seg_valid, 1'b1);
    seg_ready = 1'b1;
    stop();
    wait_idle(100, "bp");
    check_basic("bp");

    // clock enable freeze
    start(130, 2, 4, 2, P1000, 0, 1'b1, 1'b1);
    tick(); tick();
    clk_en = 1'b0;
    d = seg_data;
    repeat (3) tick();
    chk("ce_data_frozen", seg_data, d);
    chk("ce_busy_frozen", {busy, seg_valid}, 2'b11);
    clk_en = 1'b1;
    stop();
    wait_idle(100, "ce");
    check_basic("ce");

    // sliding, right
`ifdef MASK_TILE_SLIDE_EN
    sl_exp[0] = 8'b10001000; sl_exp[1] = 8'b01000100; sl_exp[2] = 8'b00100010;
    sl_exp[3] = 8'b00010001; sl_exp[4] = 8'b10001000; left_exp = 8'b00010001;
`else
    for (int i = 0; i < 5; i++) sl_exp[i] = 8'b10001000;
    left_exp = 8'b10001000;
`endif
    seg_ready = 1'b0;
    start(8, 1, 4, 1, P1000, 1, 1'b1, 1'b1);
    tick();
    for (int f = 0; f < 5; f++) begin
      if (f == 4) stop();
      seg_ready = 1'b1;
      tick();
      seg_ready = 1'b0;
    end
    wait_idle(20, "slide_r");
    chk("slide_r_count", cap_d.size(), 5);
    if (cap_d.size() == 5) begin
      for (int f = 0; f < 5; f++) begin
        d = cap_d[f];
        chk($sformatf("slide_r_frame%0d", f), d[0:7], sl_exp[f]);
      end
    end

    // sliding, left
    start(8, 1, 4, 1, P1000, 1, 1'b0, 1'b1);
    tick();
    for (int f = 0; f < 2; f++) begin
      if (f == 1) stop();
      seg_ready = 1'b1;
      tick();
      seg_ready = 1'b0;
    end
    wait_idle(20, "slide_l");
    chk("slide_l_count", cap_d.size(), 2);
    if (cap_d.size() == 2) begin
      d = cap_d[1];
      chk("slide_l_frame1", d[0:7], left_exp);
    end

    // configuration errors
    start(16, 1, 0, 1, P1000, 0, 1'b1, 1'b0);
    chk("cfgerr_pw0", {cfg_err, busy}, 2'b10);
    repeat (3) tick();
    chk("cfgerr_no_valid", seg_valid, 1'b0);
    start(16, 1081, 4, 1, P1000, 0, 1'b1, 1'b0);
    chk("cfgerr_h", {cfg_err, busy}, 2'b10);
    seg_ready = 1'b1;
    start(16, 1, 2, 1, 64'hC000_0000_0000_0000, 0, 1'b1, 1'b1);
    chk("cfgerr_cleared", {cfg_err, busy}, 2'b01);
    tick();
    stop();
    wait_idle(50, "cfgok");

    // asynchronous reset mid-stream
    start(8, 1, 4, 1, P1000, 1, 1'b1, 1'b1);
    repeat (4) tick();
    #1 rst = 1'b1;
    #1;
    chk("arst_seg_data", seg_data, 64'h0);
    chk("arst_ctrl", {seg_valid, seg_last_row, seg_last_frame, busy, cfg_err}, 5'b0);
    m_active = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    seg_ready = 1'b0;
    start(8, 1, 4, 1, P1000, 1, 1'b1, 1'b1);
    tick();
    stop();
    seg_ready = 1'b1;
    tick();
    seg_ready = 1'b0;
    wait_idle(20, "arst_restart");
    chk("arst_restart_count", cap_d.size(), 1);
    if (cap_d.size() == 1) begin
      d = cap_d[0];
      chk("arst_restart_seg", d[0:7], 8'b10001000);
    end

    // randomized streams
    for (int t = 0; t < 12; t++) begin
      start($urandom_range(1, 1920), $urandom_range(1, 20), $urandom_range(1, 8),
            $urandom_range(1, 8), {$urandom, $urandom}, $urandom_range(0, 7),
            1'($urandom_range(0, 1)), 1'b1);
      n = $urandom_range(100, 1000);
      repeat (n) begin
        seg_ready = ($urandom_range(0, 3) != 0);
        clk_en = ($urandom_range(0, 7) != 0);
        tick();
      end
      stop();
      n = 0;
      while (busy && n < 6000) begin
        seg_ready = ($urandom_range(0, 3) != 0);
        clk_en = ($urandom_range(0, 7) != 0);
        tick();
        n++;
      end
      clk_en = 1'b1;
      tick();
      wait_idle(10, $sformatf("rand%0d", t));
      chk($sformatf("rand%0d_frames", t), (m_frame > 0), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
